// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer between the bus write decode and the UART transmitter.
// Bytes are queued at bus rate and handed to the UART one at a time via a write-strobe / busy handshake.
module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int START_WAIT = 4,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [7:0]        push_data_i,
    input  logic              clear_ovf_i,
    input  logic              uart_busy_i,
    output logic              uart_wr_o,
    output logic [7:0]        uart_tx_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o
);

    localparam int TW = (START_WAIT > 1) ? $clog2(START_WAIT) : 1;
    localparam logic [ADDR_W:0] FULL_LVL   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ZERO_LVL   = (ADDR_W+1)'(0);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(START_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [7:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_s;
    state_t            state_r;
    state_t            state_s;
    logic [TW-1:0]     timer_r;
    logic [TW-1:0]     timer_s;
    logic              wr_r;
    logic [7:0]        tx_data_r;
    logic              ovf_r;
    logic              full_s;
    logic              empty_s;
    logic              push_ok_s;
    logic              drop_s;
    logic              pop_s;

    assign full_s    = (count_r == FULL_LVL);
    assign empty_s   = (count_r == ZERO_LVL);
    assign push_ok_s = push_i & ~full_s;
    assign drop_s    = push_i & full_s;

    // Drain FSM next state: the START timer bounds the wait for busy so a silent UART cannot stall the queue.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s && !uart_busy_i) begin
                    pop_s   = 1'b1;
                    timer_s = {TW{1'b0}};
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (uart_busy_i) begin
                    state_s = DONE;
                end else if (timer_r == TIMER_LAST) begin
                    state_s = IDLE;
                end else begin
                    timer_s = timer_r + TW'(1'b1);
                end
            end
            DONE: begin
                if (!uart_busy_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Occupancy update; a push and a pop in the same cycle leave the count unchanged.
    always_comb begin
        count_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_s = count_r + (ADDR_W+1)'(1'b1);
            2'b01:   count_s = count_r - (ADDR_W+1)'(1'b1);
            default: count_s = count_r;
        endcase
    end

    // FSM state and start timer registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_r <= IDLE;
            timer_r <= {TW{1'b0}};
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
        end
    end

    // Pointers, count and the registered UART-facing outputs.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_r  <= {ADDR_W{1'b0}};
            rd_ptr_r  <= {ADDR_W{1'b0}};
            count_r   <= ZERO_LVL;
            wr_r      <= 1'b0;
            tx_data_r <= 8'h00;
        end else begin
            count_r <= count_s;
            wr_r    <= pop_s;
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + ADDR_W'(1'b1);
                tx_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Sticky overflow: a dropped push beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (clear_ovf_i) begin
            ovf_r <= 1'b0;
        end
    end

    // Byte storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s && !reset_i) begin
            mem_r[wr_ptr_r] <= push_data_i;
        end
    end

    assign uart_wr_o      = wr_r;
    assign uart_tx_data_o = tx_data_r;
    assign empty_o        = empty_s;
    assign full_o         = full_s;
    assign level_o        = count_r;
    assign overflow_o     = ovf_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small UART busy responder and a strobe monitor.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       push_i = 1'b0;
    logic [7:0] push_data_i = 8'h00;
    logic       clear_ovf_i = 1'b0;
    logic       uart_busy_i;
    logic       uart_wr_o;
    logic [7:0] uart_tx_data_o;
    logic       empty_o;
    logic       full_o;
    logic [4:0] level_o;
    logic       overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic model_en    = 1'b0;
    logic manual_busy = 1'b0;
    logic model_busy  = 1'b0;
    logic pend        = 1'b0;
    logic prev_wr     = 1'b0;
    int   busy_len    = 10;
    int   busy_cnt    = 0;
    int   pulse_cnt   = 0;
    int   dbl_cnt     = 0;
    logic [7:0] rx_q[$];

    assign uart_busy_i = model_en ? model_busy : manual_busy;

    uart_tx_fifo #(.DEPTH(16), .START_WAIT(4)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .push_i         (push_i),
        .push_data_i    (push_data_i),
        .clear_ovf_i    (clear_ovf_i),
        .uart_busy_i    (uart_busy_i),
        .uart_wr_o      (uart_wr_o),
        .uart_tx_data_o (uart_tx_data_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .level_o        (level_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    // Strobe monitor plus UART model: busy rises the cycle after a strobe, for busy_len cycles.
    always @(negedge clk) begin
        if (uart_wr_o === 1'b1) begin
            rx_q.push_back(uart_tx_data_o);
            pulse_cnt++;
            if (prev_wr) dbl_cnt++;
        end
        prev_wr = (uart_wr_o === 1'b1);
        if (busy_cnt != 0) busy_cnt--;
        if (pend) begin
            busy_cnt = busy_len;
            pend = 1'b0;
        end
        if (uart_wr_o === 1'b1) pend = 1'b1;
        model_busy = (busy_cnt != 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int p0;
        reset_i = 1'b1;
        model_en = 1'b0;
        manual_busy = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty_o); end
        n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full_o); end
        n_checks++; if (level_o !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
        n_checks++; if (uart_wr_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b want 0", uart_wr_o); end
        n_checks++; if (uart_tx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", uart_tx_data_o); end
        p0 = pulse_cnt;
        repeat (6) tick();
        n_checks++; if (pulse_cnt !== p0) begin n_fail++; $display("FAIL idle_pulses got %0d want %0d", pulse_cnt, p0); end
        n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL idle_empty got %b want 1", empty_o); end
    endtask

    task automatic test_single();
        int p0;
        model_en = 1'b1;
        busy_len = 10;
        rx_q.delete();
        p0 = pulse_cnt;
        push_i = 1'b1;
        push_data_i = 8'h41;
        tick();
        push_i = 1'b0;
        n_checks++; if (level_o !== 5'd1) begin n_fail++; $display("FAIL single_level1 got %0d want 1", level_o); end
        n_checks++; if (uart_wr_o !== 1'b0) begin n_fail++; $display("FAIL single_wr_early got %b want 0", uart_wr_o); end
        tick();
        n_checks++; if (uart_wr_o !== 1'b1) begin n_fail++; $display("FAIL single_wr got %b want 1", uart_wr_o); end
        n_checks++; if (uart_tx_data_o !== 8'h41) begin n_fail++; $display("FAIL single_data got %h want 41", uart_tx_data_o); end
        n_checks++; if (level_o !== 5'd0) begin n_fail++; $display("FAIL single_level0 got %0d want 0", level_o); end
        repeat (20) tick();
        n_checks++; if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL single_pulses got %0d want 1", pulse_cnt - p0); end
        n_checks++; if (uart_tx_data_o !== 8'h41) begin n_fail++; $display("FAIL single_hold got %h want 41", uart_tx_data_o); end
    endtask

    task automatic test_overflow();
        int t;
        model_en = 1'b0;
        manual_busy = 1'b1;
        busy_len = 3;
        rx_q.delete();
        for (int i = 0; i < 16; i++) begin
            push_i = 1'b1;
            push_data_i = 8'(i);
            tick();
        end
        n_checks++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", full_o); end
        n_checks++; if (level_o !== 5'd16) begin n_fail++; $display("FAIL ovf_level16 got %0d want 16", level_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got %b want 0", overflow_o); end
        push_data_i = 8'hAA;
        tick();
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow_o); end
        n_checks++; if (level_o !== 5'd16) begin n_fail++; $display("FAIL ovf_level_hold got %0d want 16", level_o); end
        clear_ovf_i = 1'b1;
        push_data_i = 8'hBB;
        tick();
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b want 1", overflow_o); end
        push_i = 1'b0;
        tick();
        clear_ovf_i = 1'b0;
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow_o); end
        push_i = 1'b1;
        push_data_i = 8'hCC;
        model_en = 1'b1;
        tick();
        push_i = 1'b0;
        n_checks++; if (level_o !== 5'd15) begin n_fail++; $display("FAIL ovf_pop_drop_level got %0d want 15", level_o); end
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_pop_drop_flag got %b want 1", overflow_o); end
        n_checks++; if (uart_wr_o !== 1'b1) begin n_fail++; $display("FAIL ovf_first_wr got %b want 1", uart_wr_o); end
        t = 0;
        while (rx_q.size() < 16 && t < 600) begin
            tick();
            t++;
        end
        repeat (20) tick();
        n_checks++; if (rx_q.size() !== 16) begin n_fail++; $display("FAIL ovf_drain_count got %0d want 16", rx_q.size()); end
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== 8'(i)) begin n_fail++; $display("FAIL ovf_order[%0d] got %h want %h", i, rx_q[i], 8'(i)); end
        end
        clear_ovf_i = 1'b1;
        tick();
        clear_ovf_i = 1'b0;
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_final_clear got %b want 0", overflow_o); end
        n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL ovf_final_empty got %b want 1", empty_o); end
    endtask

    task automatic test_wrap();
        int p0;
        int t;
        model_en = 1'b1;
        busy_len = 2;
        rx_q.delete();
        p0 = pulse_cnt;
        for (int i = 0; i < 20; i++) begin
            push_i = 1'b1;
            push_data_i = 8'h50 + 8'(i);
            tick();
            push_i = 1'b0;
            tick();
            tick();
        end
        t = 0;
        while (rx_q.size() < 20 && t < 300) begin
            tick();
            t++;
        end
        repeat (10) tick();
        n_checks++; if (rx_q.size() !== 20) begin n_fail++; $display("FAIL wrap_count got %0d want 20", rx_q.size()); end
        for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== 8'h50 + 8'(i)) begin n_fail++; $display("FAIL wrap_order[%0d] got %h want %h", i, rx_q[i], 8'h50 + 8'(i)); end
        end
        n_checks++; if (pulse_cnt - p0 !== 20) begin n_fail++; $display("FAIL wrap_pulses got %0d want 20", pulse_cnt - p0); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got %b want 0", overflow_o); end
        n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b want 1", empty_o); end
        n_checks++; if (dbl_cnt !== 0) begin n_fail++; $display("FAIL back_to_back_strobe got %0d want 0", dbl_cnt); end
    endtask

    task automatic test_no_busy();
        logic       exp_wr;
        logic [7:0] exp_data;
        model_en = 1'b0;
        manual_busy = 1'b0;
        rx_q.delete();
        for (int k = 0; k < 25; k++) begin
            exp_wr = (k == 2) || (k == 7) || (k == 12);
            exp_data = (k == 2) ? 8'h11 : ((k == 7) ? 8'h22 : 8'h33);
            n_checks++; if (uart_wr_o !== exp_wr) begin n_fail++; $display("FAIL nobusy_wr[%0d] got %b want %b", k, uart_wr_o, exp_wr); end
            if (exp_wr) begin
                n_checks++; if (uart_tx_data_o !== exp_data) begin n_fail++; $display("FAIL nobusy_data[%0d] got %h want %h", k, uart_tx_data_o, exp_data); end
            end
            push_i = (k < 3);
            push_data_i = (k == 0) ? 8'h11 : ((k == 1) ? 8'h22 : 8'h33);
            tick();
        end
        push_i = 1'b0;
        n_checks++; if (rx_q.size() !== 3) begin n_fail++; $display("FAIL nobusy_count got %0d want 3", rx_q.size()); end
        n_checks++; if (level_o !== 5'd0) begin n_fail++; $display("FAIL nobusy_level got %0d want 0", level_o); end
    endtask

    task automatic test_reset_mid();
        int p0;
        model_en = 1'b1;
        busy_len = 10;
        for (int k = 0; k < 6; k++) begin
            push_i = 1'b1;
            push_data_i = 8'h61 + 8'(k);
            tick();
        end
        push_i = 1'b0;
        n_checks++; if (level_o !== 5'd5) begin n_fail++; $display("FAIL rstmid_pre_level got %0d want 5", level_o); end
        n_checks++; if (uart_busy_i !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy got %b want 1", uart_busy_i); end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        n_checks++; if (level_o !== 5'd0) begin n_fail++; $display("FAIL rstmid_level got %0d want 0", level_o); end
        n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty got %b want 1", empty_o); end
        n_checks++; if (uart_wr_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr got %b want 0", uart_wr_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf got %b want 0", overflow_o); end
        n_checks++; if (uart_tx_data_o !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h want 00", uart_tx_data_o); end
        p0 = pulse_cnt;
        repeat (25) tick();
        n_checks++; if (pulse_cnt !== p0) begin n_fail++; $display("FAIL rstmid_pulses got %0d want %0d", pulse_cnt, p0); end
        n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_final_empty got %b want 1", empty_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_wrap();
        test_no_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side byte buffer between the SoC bus write decode and the UART transmitter.
- Accepts bytes written to the UART data register at bus rate.
- Drains them one at a time into the UART's write strobe / busy handshake, so the CPU does not poll busy for every byte.
- Exposes fill status for the UART status register.

Parameters:
DEPTH, 16, FIFO capacity in bytes; power of two, >= 2
ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden)
START_WAIT, 4, max cycles after a write strobe to wait for uart_busy_i to rise before abandoning the handshake

Ports:
clk  input  1  system clock, all logic on rising edge
reset_i  input  1  synchronous, active-high reset
push_i  input  1  one-cycle strobe: enqueue push_data_i
push_data_i  input  8  byte to enqueue
clear_ovf_i  input  1  clears sticky overflow flag
uart_busy_i  input  1  UART transmitter busy
uart_wr_o  output  1  one-cycle write strobe to UART
uart_tx_data_o  output  8  byte presented to UART, valid when uart_wr_o=1 and held afterwards
empty_o  output  1  count == 0
full_o  output  1  count == DEPTH
level_o  output  ADDR_W+1  current count, 0..DEPTH
overflow_o  output  1  sticky: a push was dropped

Behaviour:
- Clock/reset: single clock, synchronous active-high reset on clk.
- Reset values:
  - rd/wr pointers = 0, count = 0, state = IDLE, start timer = 0.
  - uart_wr_o = 0, uart_tx_data_o = 0, overflow_o = 0.
  - Therefore empty_o = 1, full_o = 0, level_o = 0.
  - Reset mid-transfer abandons the in-flight byte and discards all queued bytes. Reset wins over every other input in the same cycle.
- Storage: DEPTH x 8 register array, circular pointers wrapping DEPTH-1 -> 0. count is tracked separately, so full and empty are unambiguous.
- Push:
  - If push_i=1 and count < DEPTH (pre-edge value): write the byte at wr_ptr, increment wr_ptr.
  - If push_i=1 and count == DEPTH: drop the byte, set overflow_o = 1. This holds even if a pop occurs in the same cycle.
- Overflow flag: cleared by clear_ovf_i. If a dropping push and clear_ovf_i occur in the same cycle, set wins.
- Simultaneous push and pop with count < DEPTH: both happen, count unchanged.
- Status outputs are combinational from count.
- Drain FSM, state IDLE:
  - If count > 0 and uart_busy_i = 0: at the edge, uart_tx_data_o <= mem[rd_ptr], uart_wr_o <= 1, increment rd_ptr, decrement count, clear timer, go to START.
  - Otherwise uart_wr_o <= 0.
- Drain FSM, state START:
  - uart_wr_o <= 0.
  - If uart_busy_i = 1: go to DONE.
  - Else if timer == START_WAIT-1: go to IDLE (byte considered consumed; no retry).
  - Else increment timer.
- Drain FSM, state DONE:
  - uart_wr_o <= 0.
  - When uart_busy_i = 0: go to IDLE.
- uart_wr_o is never high on two consecutive cycles. At most one byte is in flight.
- Latency: a push into an empty FIFO with the drain FSM in IDLE and UART idle gives uart_wr_o = 1 two cycles after push_i, i.e. in the cycle after the pushed byte is visible in count. Back-to-back bytes are separated by at least the UART busy period plus 1 cycle in IDLE.
- uart_tx_data_o holds its value until the next pop.

Test Plan:
- Reset then idle, uart_busy_i=0 -> uart_wr_o stays 0, empty_o=1, level_o=0, overflow_o=0.
- Push 0x41 into empty FIFO; UART model raises busy 1 cycle after the strobe for 10 cycles -> uart_wr_o pulses once 2 cycles after push with uart_tx_data_o=0x41. No second pulse until busy falls. level_o goes 0->1->0.
- Push 0x00..0x0F on 16 consecutive cycles with uart_busy_i held 1 -> full_o=1, level_o=16. A 17th push of 0xAA sets overflow_o=1 and level_o stays 16. Release busy, then drain: output order is 0x00..0x0F with no 0xAA. clear_ovf_i clears overflow_o.
- Push 20 bytes interleaved with draining so the pointers wrap -> all 20 bytes emerge in order, with no loss or duplication.
- UART model never asserts busy (START_WAIT=4) -> after a pulse, FSM returns to IDLE after 4 START cycles. The next queued byte is strobed, and each byte is strobed exactly once.
- Assert reset_i with 5 bytes queued while in DONE -> next cycle level_o=0, empty_o=1, uart_wr_o=0, overflow_o=0. No further strobes after busy falls.
